pc_gen: RTL and testbench

- Parametrised program-counter generator for the RISC-V pipeline fetch stage; successor to the plain PC register.
- Holds the architectural fetch PC and computes the sequential next PC.
- Arbitrates redirects from the trap logic, the EX branch unit and the ID jump decoder, and handshakes with instruction memory.
- Adds a boot/run/halt state machine, misaligned-target detection and a fetch counter.

---
 rtl/pc_gen_if.sv | 34 +++
 rtl/pc_gen.sv | 119 +++++++++++
 tb/tb_pc_gen.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_if.sv
// Fetch-stage bus between the pipeline control logic and the PC generator.
// slave is the PC generator side; master is the driver/observer side.
interface pc_gen_if #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 32
);
   logic             pc_write;
   logic             fetch_ready;
   logic             trap;
   logic             br_taken;
   logic [XLEN-1:0]  br_target;
   logic             jmp_valid;
   logic [XLEN-1:0]  jmp_target;
   logic             halt_req;
   logic             resume;
   logic [XLEN-1:0]  pc_out;
   logic [XLEN-1:0]  pc_plus;
   logic             fetch_valid;
   logic             misaligned;
   logic             halted;
   logic [CNT_W-1:0] fetch_count;

   modport master (
      output pc_write, fetch_ready, trap, br_taken, br_target,
             jmp_valid, jmp_target, halt_req, resume,
      input  pc_out, pc_plus, fetch_valid, misaligned, halted, fetch_count
   );

   modport slave (
      input  pc_write, fetch_ready, trap, br_taken, br_target,
             jmp_valid, jmp_target, halt_req, resume,
      output pc_out, pc_plus, fetch_valid, misaligned, halted, fetch_count
   );
endinterface

// File: rtl/pc_gen.sv
// Fetch program-counter generator: boot/run/halt control, prioritised redirects
// (trap > branch > jump > sequential), misaligned-target trapping and fetch counting.
module pc_gen #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int unsigned     ILEN_BYTES   = 4,
   parameter int unsigned     CNT_W        = 32
) (
   input logic    clk,
   input logic    reset,
   pc_gen_if.slave bus
);

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_HALT = 2'd2;

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);
   localparam logic [XLEN-1:0] PC_INC     = XLEN'(ILEN_BYTES);

   logic [1:0]       state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fetch_valid_q, fetch_valid_d;
   logic             misaligned_q, misaligned_d;
   logic             halted_q, halted_d;

   logic [XLEN-1:0]  pc_plus_c;
   logic             accept_c;
   logic             redirect_c;
   logic             br_mis_c;
   logic             jmp_mis_c;

   assign pc_plus_c = pc_q + PC_INC;
   assign accept_c  = (state_q == ST_RUN) & fetch_valid_q & bus.fetch_ready & bus.pc_write;
   assign br_mis_c  = (bus.br_target & ALIGN_MASK) != '0;
   assign jmp_mis_c = (bus.jmp_target & ALIGN_MASK) != '0;

   // Next-state, next-PC and counter selection.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      cnt_d        = cnt_q;
      misaligned_d = 1'b0;
      redirect_c   = 1'b0;

      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end

         ST_RUN: begin
            if (bus.trap) begin
               redirect_c = 1'b1;
               pc_d       = TRAP_VECTOR;
            end else if (bus.br_taken) begin
               redirect_c   = 1'b1;
               pc_d         = br_mis_c ? TRAP_VECTOR : bus.br_target;
               misaligned_d = br_mis_c;
            end else if (bus.jmp_valid && bus.pc_write) begin
               redirect_c   = 1'b1;
               pc_d         = jmp_mis_c ? TRAP_VECTOR : bus.jmp_target;
               misaligned_d = jmp_mis_c;
            end else if (accept_c) begin
               pc_d  = pc_plus_c;
               cnt_d = cnt_q + CNT_W'(1);
            end

            // Halt only on a cycle that moves the PC, so no redirect is lost.
            if (bus.halt_req && (accept_c || redirect_c)) begin
               state_d = ST_HALT;
            end
         end

         ST_HALT: begin
            if (bus.trap) begin
               state_d = ST_RUN;
               pc_d    = TRAP_VECTOR;
            end else if (bus.resume) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d = ST_BOOT;
         end
      endcase

      fetch_valid_d = (state_d == ST_RUN);
      halted_d      = (state_d == ST_HALT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_VECTOR;
         cnt_q         <= '0;
         fetch_valid_q <= 1'b0;
         misaligned_q  <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         cnt_q         <= cnt_d;
         fetch_valid_q <= fetch_valid_d;
         misaligned_q  <= misaligned_d;
         halted_q      <= halted_d;
      end
   end

   assign bus.pc_out      = pc_q;
   assign bus.pc_plus     = pc_plus_c;
   assign bus.fetch_valid = fetch_valid_q;
   assign bus.misaligned  = misaligned_q;
   assign bus.halted      = halted_q;
   assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a 32-bit default instance and an 8-bit / 2-bit-counter
// instance for wrap behaviour, with expected outputs queued per step.
module tb_pc_gen;

   typedef struct packed {
      logic [31:0] pc;
      logic        fv;
      logic        mis;
      logic        hlt;
      logic [31:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic reset8;

   int checks = 0;
   int errors = 0;

   exp_t  exp_q[$];
   string tag_q[$];

   pc_gen_if #(.XLEN(32), .CNT_W(32)) bus ();
   pc_gen_if #(.XLEN(8),  .CNT_W(2))  bus8 ();

   pc_gen dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   pc_gen #(
      .XLEN         (8),
      .RESET_VECTOR (8'hF4),
      .TRAP_VECTOR  (8'h10),
      .ILEN_BYTES   (4),
      .CNT_W        (2)
   ) dut8 (
      .clk   (clk),
      .reset (reset8),
      .bus   (bus8.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input string fld,
                      input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s.%s observed %h expected %h", tag, fld, obs, expv);
      end
   endtask

   task automatic drv(input logic pw, input logic fr, input logic tr,
                      input logic bt, input logic [31:0] btg,
                      input logic jv, input logic [31:0] jtg,
                      input logic hr, input logic rs);
      bus.pc_write    = pw;
      bus.fetch_ready = fr;
      bus.trap        = tr;
      bus.br_taken    = bt;
      bus.br_target   = btg;
      bus.jmp_valid   = jv;
      bus.jmp_target  = jtg;
      bus.halt_req    = hr;
      bus.resume      = rs;
   endtask

   // Queue the expected post-edge outputs, advance one clock, then pop and compare.
   task automatic step(input bit sel, input string tag, input logic [31:0] epc,
                       input logic efv, input logic emis, input logic ehlt,
                       input logic [31:0] ecnt);
      exp_t e;
      exp_t got;
      string t;
      exp_q.push_back('{pc: epc, fv: efv, mis: emis, hlt: ehlt, cnt: ecnt});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      if (sel) begin
         got = '{pc: 32'(bus8.pc_out), fv: bus8.fetch_valid, mis: bus8.misaligned,
                 hlt: bus8.halted, cnt: 32'(bus8.fetch_count)};
      end else begin
         got = '{pc: bus.pc_out, fv: bus.fetch_valid, mis: bus.misaligned,
                 hlt: bus.halted, cnt: bus.fetch_count};
      end
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      chk(t, "pc_out",      got.pc,         e.pc);
      chk(t, "fetch_valid", 32'(got.fv),    32'(e.fv));
      chk(t, "misaligned",  32'(got.mis),   32'(e.mis));
      chk(t, "halted",      32'(got.hlt),   32'(e.hlt));
      chk(t, "fetch_count", got.cnt,        e.cnt);
   endtask

   initial begin
      reset  = 1'b1;
      reset8 = 1'b1;
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      bus8.pc_write    = 1'b1;
      bus8.fetch_ready = 1'b1;
      bus8.trap        = 1'b0;
      bus8.br_taken    = 1'b0;
      bus8.br_target   = 8'h00;
      bus8.jmp_valid   = 1'b0;
      bus8.jmp_target  = 8'h00;
      bus8.halt_req    = 1'b0;
      bus8.resume      = 1'b0;

      // Reset and boot.
      step(0, "rst1", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
      step(0, "rst2", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      step(0, "boot_exit", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);
      chk("boot_exit", "pc_plus", bus.pc_plus, 32'h4);
      step(0, "seq4", 32'h4, 1'b1, 1'b0, 1'b0, 32'd1);
      step(0, "seq8", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);

      // Stall by pc_write, then by fetch_ready.
      drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(0, "stall_pw", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);
      drv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(0, "stall_fr", 32'h8, 1'b1, 1'b0, 1'b0, 32'd2);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(0, "seq12", 32'hC, 1'b1, 1'b0, 1'b0, 32'd3);

      // Priority: trap over branch over jump; no count on redirects.
      drv(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0);
      step(0, "prio_trap", 32'h100, 1'b1, 1'b0, 1'b0, 32'd3);
      drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0);
      step(0, "br_only", 32'h40, 1'b1, 1'b0, 1'b0, 32'd3);
      drv(1'b1, 1'b1, 1'b0, 1'b1, 32'h60, 1'b1, 32'h80, 1'b0, 1'b0);
      step(0, "br_over_jmp", 32'h60, 1'b1, 1'b0, 1'b0, 32'd3);
      drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h80, 1'b0, 1'b0);
      step(0, "jmp_no_pw", 32'h60, 1'b1, 1'b0, 1'b0, 32'd3);

      // Misaligned jump/branch targets trap with a one-cycle pulse.
      drv(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h22, 1'b0, 1'b0);
      step(0, "jmp_mis", 32'h100, 1'b1, 1'b1, 1'b0, 32'd3);
      drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(0, "mis_end", 32'h100, 1'b1, 1'b0, 1'b0, 32'd3);
      drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h22, 1'b0, 1'b0);
      step(0, "mis_trap", 32'h100, 1'b1, 1'b0, 1'b0, 32'd3);
      drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h42, 1'b0, 32'h0, 1'b0, 1'b0);
      step(0, "br_mis", 32'h100, 1'b1, 1'b1, 1'b0, 32'd3);

      // Halt on an accept, ignore inputs while halted, resume.
      drv(1'b0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0);
      step(0, "br_10", 32'h10, 1'b1, 1'b0, 1'b0, 32'd3);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(0, "halt_acc", 32'h14, 1'b0, 1'b0, 1'b1, 32'd4);
      drv(1'b1, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h90, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(0, "halt_hold", 32'h14, 1'b0, 1'b0, 1'b1, 32'd4);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(0, "resume", 32'h14, 1'b1, 1'b0, 1'b0, 32'd4);
      drv(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
      step(0, "halt_wait", 32'h14, 1'b1, 1'b0, 1'b0, 32'd4);
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(0, "halt_acc2", 32'h18, 1'b0, 1'b0, 1'b1, 32'd5);
      drv(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
      step(0, "halt_trap", 32'h100, 1'b1, 1'b0, 1'b0, 32'd5);
      drv(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 1'b0);
      step(0, "halt_redir", 32'h200, 1'b0, 1'b0, 1'b1, 32'd5);

      // Reset while halted, then a trap during BOOT is ignored.
      reset = 1'b1;
      drv(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(0, "rst_halt", 32'h0, 1'b0, 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      drv(1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      step(0, "boot_trap", 32'h0, 1'b1, 1'b0, 1'b0, 32'd0);

      // 8-bit PC and 2-bit counter wrap.
      reset8 = 1'b0;
      step(1, "w_boot", 32'hF4, 1'b1, 1'b0, 1'b0, 32'd0);
      step(1, "w_f8",   32'hF8, 1'b1, 1'b0, 1'b0, 32'd1);
      step(1, "w_fc",   32'hFC, 1'b1, 1'b0, 1'b0, 32'd2);
      chk("w_fc", "pc_plus", 32'(bus8.pc_plus), 32'h00);
      step(1, "w_00",   32'h00, 1'b1, 1'b0, 1'b0, 32'd3);
      step(1, "w_cnt",  32'h04, 1'b1, 1'b0, 1'b0, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
